// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer for the sCPU.
// Fetches the instruction at pc over a req/ack handshake, then waits in EXEC for the next PC.
module pc_fetch_unit #(
  parameter int unsigned INST_W      = 8,
  parameter logic [3:0]  RESET_PC    = 4'h0,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic [3:0]        next_pc,
  input  logic              exec_done,
  output logic              imem_req,
  output logic [3:0]        imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_data,
  output logic [3:0]        pc,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              empty_inst,
  output logic              running,
  output logic              fault,
  output logic [7:0]        retired
);

  localparam int unsigned PC_W  = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned RET_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [RET_W-1:0] RET_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [INST_W-1:0]   r_inst;
  logic [RET_W-1:0]    r_retired;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_fault;
  logic                r_halt_pending;

  state_t              w_state;
  logic [PC_W-1:0]     w_pc;
  logic [INST_W-1:0]   w_inst;
  logic [RET_W-1:0]    w_retired;
  logic [CNT_W-1:0]    w_cnt;
  logic                w_fault;
  logic                w_halt_pending;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_inst         <= '0;
      r_retired      <= '0;
      r_cnt          <= '0;
      r_fault        <= 1'b0;
      r_halt_pending <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_pc           <= w_pc;
      r_inst         <= w_inst;
      r_retired      <= w_retired;
      r_cnt          <= w_cnt;
      r_fault        <= w_fault;
      r_halt_pending <= w_halt_pending;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    w_state        = r_state;
    w_pc           = r_pc;
    w_inst         = r_inst;
    w_retired      = r_retired;
    w_cnt          = r_cnt;
    w_fault        = r_fault;
    w_halt_pending = r_halt_pending;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_cnt   = '0;
          w_state = S_REQ;
        end
      end

      S_REQ: begin
        if (halt_req) begin
          w_halt_pending = 1'b1;
        end
        // An ack on the last allowed cycle wins over the timeout
        if (imem_ack) begin
          w_inst  = imem_data;
          w_cnt   = '0;
          w_state = S_EXEC;
        end else if (r_cnt == CNT_LAST) begin
          w_fault = 1'b1;
          w_cnt   = '0;
          w_state = S_HALT;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_EXEC: begin
        if (exec_done) begin
          w_pc = next_pc;
          if (r_retired != RET_MAX) begin
            w_retired = r_retired + RET_W'(1);
          end
          w_state = (halt_req || r_halt_pending) ? S_HALT : S_REQ;
        end
      end

      S_HALT: begin
        if (start) begin
          w_pc           = RESET_PC;
          w_fault        = 1'b0;
          w_retired      = '0;
          w_halt_pending = 1'b0;
          w_cnt          = '0;
          w_state        = S_REQ;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // Output decodes of registered state only; no path from imem_ack
  assign imem_req   = (r_state == S_REQ);
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign inst       = r_inst;
  assign inst_valid = (r_state == S_EXEC);
  assign empty_inst = (r_state == S_EXEC) && (r_inst == '0);
  assign running    = (r_state == S_REQ) || (r_state == S_EXEC);
  assign fault      = r_fault;
  assign retired    = r_retired;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: stimulus pushes expected retirements into a queue,
// a negedge monitor pops and compares each time an instruction retires.
module tb_pc_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       halt_req;
  logic [3:0] next_pc;
  logic       exec_done;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [3:0] pc;
  logic [7:0] inst;
  logic       inst_valid;
  logic       empty_inst;
  logic       running;
  logic       fault;
  logic [7:0] retired;

  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] inst;
    logic       empty;
    logic [7:0] ret;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  logic [3:0] m_pc     = 4'h0;
  logic [7:0] m_ret    = 8'h00;

  pc_fetch_unit #(
    .INST_W      (8),
    .RESET_PC    (4'h0),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt_req   (halt_req),
    .next_pc    (next_pc),
    .exec_done  (exec_done),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .empty_inst (empty_inst),
    .running    (running),
    .fault      (fault),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one pop per retirement
  always @(negedge clk) begin
    if (rst_n && inst_valid && exec_done) begin
      if (q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_retire: pc %0h inst %0h with no expectation queued", pc, inst);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ret_pc", pc, e.pc);
        chk("ret_inst", inst, e.inst);
        chk("ret_empty", empty_inst, e.empty);
        chk("ret_count", retired, e.ret);
      end
    end
  end

  // Fetch with ack_dly wait cycles, then execute with exec_dly wait cycles
  task automatic run_instr(input int ack_dly, input logic [7:0] data, input logic [3:0] npc,
                           input int exec_dly, input bit hreq);
    exp_t e;
    e.pc    = m_pc;
    e.inst  = data;
    e.empty = (data == 8'h00);
    e.ret   = m_ret;
    q.push_back(e);
    for (int i = 0; i <= ack_dly; i++) begin
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, m_pc);
      halt_req  = hreq && (i == 0);
      imem_ack  = (i == ack_dly);
      imem_data = (i == ack_dly) ? data : 8'hEE;
      step;
    end
    imem_ack = 1'b0;
    halt_req = 1'b0;
    chk("inst_cap", inst, data);
    for (int j = 0; j <= exec_dly; j++) begin
      exec_done = (j == exec_dly);
      next_pc   = npc;
      step;
    end
    exec_done = 1'b0;
    m_pc = npc;
    if (m_ret != 8'hFF) m_ret = m_ret + 8'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; next_pc = 4'h0;
    exec_done = 1'b0; imem_ack = 1'b0; imem_data = 8'h00;
    #12;
    chk("rst_pc", pc, 4'h0);
    chk("rst_inst", inst, 8'h00);
    chk("rst_retired", retired, 8'h00);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_running", running, 0);
    chk("rst_fault", fault, 0);
    rst_n = 1'b1;
    step;
    chk("idle_req", imem_req, 0);

    // Basic fetch/execute, minimum 2-cycle period
    start = 1'b1; step; start = 1'b0;
    chk("start_running", running, 1);
    run_instr(0, 8'h35, 4'h1, 0, 0);
    chk("first_pc", pc, 4'h1);
    chk("first_retired", retired, 8'h01);
    chk("first_back_req", imem_req, 1);

    // Delayed ack, slow execute
    run_instr(3, 8'hA7, 4'hF, 1, 0);
    chk("dly_fault", fault, 0);
    chk("dly_pc", pc, 4'hF);

    // Empty instruction and pc wrap F -> 0
    run_instr(0, 8'h00, 4'h0, 0, 0);
    chk("wrap_pc", pc, 4'h0);

    // halt_req in REQ: instruction still executes, then HALT
    run_instr(2, 8'h5C, 4'h9, 0, 1);
    chk("halt_running", running, 0);
    chk("halt_req_low", imem_req, 0);
    chk("halt_pc", pc, 4'h9);
    chk("halt_retired", retired, 8'h04);
    exec_done = 1'b1; next_pc = 4'h3; step; exec_done = 1'b0;
    chk("halt_ignore_done", pc, 4'h9);
    step;
    chk("halt_hold_ret", retired, 8'h04);
    start = 1'b1; step; start = 1'b0;
    chk("restart_pc", pc, 4'h0);
    chk("restart_retired", retired, 8'h00);
    chk("restart_running", running, 1);
    m_pc = 4'h0; m_ret = 8'h00;

    // Ack never arrives: fault after 8 REQ cycles
    for (int i = 0; i < 8; i++) begin
      chk("to_req", imem_req, 1);
      chk("to_no_fault_yet", fault, 0);
      step;
    end
    chk("to_fault", fault, 1);
    chk("to_halted", running, 0);
    start = 1'b1; step; start = 1'b0;
    chk("to_fault_clear", fault, 0);

    // Ack on the 8th cycle exactly: no fault
    run_instr(7, 8'h42, 4'h2, 0, 0);
    chk("edge_no_fault", fault, 0);
    chk("edge_pc", pc, 4'h2);

    // Asynchronous reset while in EXEC
    imem_ack = 1'b1; imem_data = 8'h77; step; imem_ack = 1'b0;
    chk("pre_rst_valid", inst_valid, 1);
    chk("pre_rst_inst", inst, 8'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 4'h0);
    chk("arst_inst", inst, 8'h00);
    chk("arst_valid", inst_valid, 0);
    chk("arst_running", running, 0);
    chk("arst_retired", retired, 8'h00);
    chk("arst_empty", empty_inst, 0);
    exec_done = 1'b1; next_pc = 4'h5;
    step;
    rst_n = 1'b1;
    step;
    exec_done = 1'b0;
    chk("post_rst_pc", pc, 4'h0);
    chk("post_rst_retired", retired, 8'h00);
    chk("post_rst_running", running, 0);

    step;
    chk("scoreboard_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the sCPU.
- Holds the 4-bit PC, fetches the instruction at PC from instruction memory over a req/ack handshake, and presents the instruction to decode/execute.
- When execute signals completion, it loads the next PC produced by the PC-update logic.
- Sits between instruction memory and the PC-update/execute stages. It is the register stage that consumes the next-PC value.

Parameters:
- INST_W, 8, instruction width in bits.
- RESET_PC, 4'h0, PC value after reset and on restart.
- ACK_TIMEOUT, 8, maximum cycles to wait for imem_ack before faulting (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  begin or restart execution from RESET_PC (sampled in IDLE or HALT only).
- halt_req  input  1  stop after the current instruction retires.
- next_pc  input  4  next PC from the PC-update logic, valid while exec_done=1.
- exec_done  input  1  execute stage has finished the current instruction.
- imem_req  output  1  fetch request.
- imem_addr  output  4  fetch address (equals pc).
- imem_ack  input  1  instruction memory has imem_data valid this cycle.
- imem_data  input  INST_W  instruction word.
- pc  output  4  current PC.
- inst  output  INST_W  instruction register.
- inst_valid  output  1  inst is valid for decode/execute.
- empty_inst  output  1  inst is all-zero (empty slot); qualified by inst_valid.
- running  output  1  FSM is in REQ or EXEC.
- fault  output  1  fetch timeout occurred; sticky until restart.
- retired  output  8  count of retired instructions, saturating at 255.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = IDLE.
  - pc = RESET_PC.
  - inst, retired and the timeout counter = 0.
  - imem_req, inst_valid, running and fault = 0.
  - The halt_pending latch = 0.
  - Reset asserted mid-handshake abandons the fetch immediately. An ack arriving during or after reset is ignored.
- States:
  - IDLE: all outputs are idle. start=1 -> REQ, with the timeout counter cleared.
  - REQ:
    - imem_req=1 and imem_addr=pc, held until ack.
    - On imem_ack=1: inst <= imem_data, the counter is cleared -> EXEC. Data is captured in the same cycle as the ack, with no extra wait state.
    - Each cycle without ack increments the counter. When the counter reaches ACK_TIMEOUT-1 with no ack: fault <= 1 -> HALT. An ack in that same cycle takes priority: it is captured and there is no fault.
  - EXEC:
    - inst_valid=1, held until exec_done.
    - empty_inst = (inst == 0).
    - On exec_done=1: pc <= next_pc and retired <= retired+1 (holds at 255). Then -> HALT if (halt_req or halt_pending), else -> REQ.
    - exec_done outside EXEC is ignored.
  - HALT:
    - pc, inst and retired hold.
    - imem_req=0, inst_valid=0, running=0.
    - start=1: pc <= RESET_PC, fault <= 0, retired <= 0, halt_pending <= 0 -> REQ.
- halt_req:
  - Asserted in REQ: sets halt_pending; the fetch completes and the instruction executes before halting.
  - Asserted in IDLE or HALT: ignored.
- start:
  - Asserted in REQ or EXEC: ignored.
  - start and halt_req together in IDLE: start wins, halt_req is ignored.
- PC arithmetic:
  - PC is not incremented here; the value comes solely from next_pc, which is already modulo 16.
  - pc=4'hF with next_pc=4'h0 wraps with no special handling.
- Timing:
  - Minimum instruction period is 2 cycles: one REQ cycle with immediate ack, then one EXEC cycle with immediate exec_done.
  - imem_addr and imem_req are registered-state decodes with no combinational path from imem_ack.

Test Plan:
- Reset then start=1, imem_ack immediate, imem_data=8'h35, exec_done immediate, next_pc=4'h1 -> imem_addr=0, inst=8'h35, inst_valid for 1 cycle, pc=1 and retired=1 two cycles after start.
- imem_ack delayed 3 cycles -> imem_req stays 1 with imem_addr stable for 4 cycles, inst captured on the ack cycle, no fault.
- imem_data=8'h00 -> empty_inst=1 while inst_valid. With pc=4'hF and next_pc=4'h0 -> pc wraps to 0.
- halt_req pulsed during REQ, ack after 2 cycles -> the instruction executes, retired increments, state HALT, pc=next_pc. A later start -> pc=RESET_PC, retired=0.
- imem_ack never asserted with ACK_TIMEOUT=8 -> fault=1 and HALT after 8 REQ cycles. start clears fault. Ack on cycle 8 exactly -> no fault.
- rst_n dropped while in EXEC -> all outputs reset asynchronously before the next clock edge, and a subsequent exec_done is ignored.
